// File: rtl/alu_arb.sv
// Round-robin arbiter that serialises requester operations onto one shared ALU.
// Each operation is granted, executed, then its result is returned.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

// state | meaning
// IDLE  | waiting for a request; alu_*_o hold the last issued operation
// EXEC  | granted operation is on the ALU; the result is captured at the next edge
// RESP  | result strobe is ending; grant is cleared and the pointer advances
module alu_arb #(
  parameter int WORD_LEN = 64,
  parameter int N_REQ    = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ*WORD_LEN-1:0]    op_a_i,
  input  logic [N_REQ*WORD_LEN-1:0]    op_b_i,
  input  alu_pkg::alu_op_t             opc_i [N_REQ],
  output logic [N_REQ-1:0]             gnt_o,
  output logic [WORD_LEN-1:0]          res_o,
  output logic [N_REQ-1:0]             res_valid_o,
  output logic                         busy_o,
  output logic [WORD_LEN-1:0]          alu_op_a_o,
  output logic [WORD_LEN-1:0]          alu_op_b_o,
  output alu_pkg::alu_op_t             alu_opc_o,
  input  logic [WORD_LEN-1:0]          alu_res_i
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [GW-1:0] g;
  logic [GW-1:0] rr;
  logic [GW-1:0] pick;
  logic          found;

  // First asserted request scanning upward from rr, wrapping around.
  always_comb begin
    int j;
    pick  = rr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(rr) + i) % N_REQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      g           <= '0;
      rr          <= '0;
      gnt_o       <= '0;
      res_o       <= '0;
      res_valid_o <= '0;
      busy_o      <= 1'b0;
      alu_op_a_o  <= '0;
      alu_op_b_o  <= '0;
      alu_opc_o   <= alu_pkg::alu_op_t'(0);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            g          <= pick;
            gnt_o      <= N_REQ'(1) << pick;
            busy_o     <= 1'b1;
            alu_op_a_o <= op_a_i[pick*WORD_LEN +: WORD_LEN];
            alu_op_b_o <= op_b_i[pick*WORD_LEN +: WORD_LEN];
            alu_opc_o  <= opc_i[pick];
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_o       <= alu_res_i;
          res_valid_o <= gnt_o;
          state       <= RESP;
        end
        RESP: begin
          res_valid_o <= '0;
          gnt_o       <= '0;
          busy_o      <= 1'b0;
          rr          <= (g == GW'(N_REQ - 1)) ? '0 : g + 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a small combinational ALU attached.
module tb_alu_arb;
  import alu_pkg::*;

  localparam int W = 64;
  localparam int N = 2;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N-1:0]     req;
  logic [N*W-1:0]   op_a;
  logic [N*W-1:0]   op_b;
  alu_op_t          opc [N];
  logic [N-1:0]     gnt;
  logic [W-1:0]     res;
  logic [N-1:0]     res_valid;
  logic             busy;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  alu_op_t          alu_opc;
  logic [W-1:0]     alu_res;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  alu_arb #(.WORD_LEN(W), .N_REQ(N)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .opc_i       (opc),
    .gnt_o       (gnt),
    .res_o       (res),
    .res_valid_o (res_valid),
    .busy_o      (busy),
    .alu_op_a_o  (alu_a),
    .alu_op_b_o  (alu_b),
    .alu_opc_o   (alu_opc),
    .alu_res_i   (alu_res)
  );

  always_comb begin
    alu_res = '0;
    case (alu_opc)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_XOR: alu_res = alu_a ^ alu_b;
      default: alu_res = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full grant/exec/resp sequence starting from IDLE with a request pending.
  task automatic op_cycle(input string tag, input logic [N-1:0] exp_gnt,
                          input logic [63:0] exp_a, input logic [63:0] exp_res);
    tick();
    chk({tag, "_gnt"},   64'(gnt), 64'(exp_gnt));
    chk({tag, "_busy"},  64'(busy), 64'd1);
    chk({tag, "_alu_a"}, alu_a, exp_a);
    chk({tag, "_rv0"},   64'(res_valid), 64'd0);
    tick();
    chk({tag, "_gnt2"},  64'(gnt), 64'(exp_gnt));
    chk({tag, "_rv"},    64'(res_valid), 64'(exp_gnt));
    chk({tag, "_res"},   res, exp_res);
    tick();
    chk({tag, "_gnt_off"},  64'(gnt), 64'd0);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_rv_off"},   64'(res_valid), 64'd0);
  endtask

  initial begin
    reset_i = 1'b1;
    req     = '0;
    op_a    = '0;
    op_b    = '0;
    opc[0]  = ALU_ADD;
    opc[1]  = ALU_ADD;
    tick();
    tick();
    chk("rst_gnt",  64'(gnt), 64'd0);
    chk("rst_rv",   64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res",  res, 64'd0);
    chk("rst_a",    alu_a, 64'd0);
    chk("rst_b",    alu_b, 64'd0);
    chk("rst_opc",  64'(alu_opc), 64'd0);
    reset_i = 1'b0;
    tick();

    // Single request: 5 + 3
    op_a[0*W +: W] = 64'd5;
    op_b[0*W +: W] = 64'd3;
    opc[0] = ALU_ADD;
    req = 2'b01;
    op_cycle("single", 2'b01, 64'd5, 64'd8);
    req = 2'b00;
    tick();
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_res_hold",  res, 64'd8);
    chk("single_a_hold",    alu_a, 64'd5);

    // Requester 1 alone, rr moves from 1 back to 0
    op_a[1*W +: W] = 64'hAA;
    op_b[1*W +: W] = 64'h0F;
    opc[1] = ALU_XOR;
    req = 2'b10;
    op_cycle("r1_alone", 2'b10, 64'hAA, 64'hA5);
    req = 2'b00;
    tick();

    // Simultaneous: wrap gives requester 0 first, then alternation
    op_a[0*W +: W] = 64'd10;
    op_b[0*W +: W] = 64'd4;
    opc[0] = ALU_SUB;
    op_a[1*W +: W] = 64'hF0;
    op_b[1*W +: W] = 64'h0F;
    opc[1] = ALU_OR;
    req = 2'b11;
    op_cycle("both_r0", 2'b01, 64'd10, 64'd6);
    op_cycle("both_r1", 2'b10, 64'hF0, 64'hFF);
    op_cycle("both_r0b", 2'b01, 64'd10, 64'd6);
    req = 2'b00;
    tick();

    // Drop after grant; rr currently 1 but only requester 0 asks
    op_a[0*W +: W] = 64'hFF;
    op_b[0*W +: W] = 64'h0F;
    opc[0] = ALU_AND;
    req = 2'b01;
    tick();
    chk("drop_gnt", 64'(gnt), 64'd1);
    req = 2'b00;
    tick();
    chk("drop_rv",  64'(res_valid), 64'd1);
    chk("drop_res", res, 64'h0F);
    tick();
    chk("drop_idle", 64'(gnt), 64'd0);
    tick();
    chk("drop_no_regrant", 64'(gnt), 64'd0);
    chk("drop_no_busy",    64'(busy), 64'd0);

    // Reset mid-operation: rr=1 so requester 1 is granted first
    op_a[0*W +: W] = 64'd10;
    op_b[0*W +: W] = 64'd4;
    opc[0] = ALU_SUB;
    req = 2'b11;
    tick();
    chk("rmid_gnt", 64'(gnt), 64'd2);
    reset_i = 1'b1;
    tick();
    chk("rmid_gnt0",  64'(gnt), 64'd0);
    chk("rmid_rv0",   64'(res_valid), 64'd0);
    chk("rmid_busy0", 64'(busy), 64'd0);
    chk("rmid_res0",  res, 64'd0);
    chk("rmid_a0",    alu_a, 64'd0);
    reset_i = 1'b0;
    op_cycle("post_rst", 2'b01, 64'd10, 64'd6);
    req = 2'b00;
    tick();

    // Operand capture at the grant edge
    op_a[0*W +: W] = 64'd100;
    op_b[0*W +: W] = 64'd1;
    opc[0] = ALU_ADD;
    req = 2'b01;
    tick();
    chk("cap_gnt", 64'(gnt), 64'd1);
    op_a[0*W +: W] = 64'd7;
    tick();
    chk("cap_res", res, 64'd101);
    chk("cap_rv",  64'(res_valid), 64'd1);
    req = 2'b00;
    tick();
    chk("cap_a_hold", alu_a, 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
